// File: rtl/audio_sample_fifo.sv
// audio_sample_fifo: first-word-fall-through stereo sample FIFO between an
// audio generator and an HDMI audio packetizer, single clock (clk_pixel).
// Pointers carry one extra wrap bit so full and empty are distinguishable.
// Optional feature macro: AUDIO_FIFO_STATS_EN enables the saturating
// overflow/underflow event counters; otherwise both outputs read as zero.
module audio_sample_fifo #(
  parameter int BIT_WIDTH = 16,
  parameter int DEPTH     = 8
) (
  input  logic                          clk_pixel,
  input  logic                          reset,
  input  logic                          in_valid,
  input  logic signed [BIT_WIDTH-1:0]   in_left,
  input  logic signed [BIT_WIDTH-1:0]   in_right,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic signed [BIT_WIDTH-1:0]   out_left,
  output logic signed [BIT_WIDTH-1:0]   out_right,
  output logic [$clog2(DEPTH):0]        fill_level,
  output logic [7:0]                    overflow_count,
  output logic [7:0]                    underflow_count
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]            wr_ptr;
  logic [AW:0]            rd_ptr;
  logic [2*BIT_WIDTH-1:0] mem [DEPTH];
  logic [2*BIT_WIDTH-1:0] head;
  logic                   empty;
  logic                   full;
  logic                   rd_en;
  logic                   wr_en;

  // Status, handshake decode and head presentation, all from registered state
  always_comb begin
    empty      = (wr_ptr == rd_ptr);
    full       = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    fill_level = wr_ptr - rd_ptr;
    out_valid  = !empty;
    rd_en      = !empty && out_ready;
    // A full FIFO still accepts a sample when the head leaves in the same cycle
    wr_en      = in_valid && (!full || rd_en);
    head       = mem[rd_ptr[AW-1:0]];
    out_left   = '0;
    out_right  = '0;
    if (out_valid) begin
      out_left  = head[2*BIT_WIDTH-1:BIT_WIDTH];
      out_right = head[BIT_WIDTH-1:0];
    end
  end

  // Pointer registers; reset empties the FIFO immediately
  always_ff @(posedge clk_pixel or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Sample storage, left and right packed together; contents survive reset
  always_ff @(posedge clk_pixel) begin
    if (wr_en && !reset) mem[wr_ptr[AW-1:0]] <= {in_left, in_right};
  end

`ifdef AUDIO_FIFO_STATS_EN
  logic drop;
  logic underflow;

  // Event decode: sample dropped at full, or read attempted while empty
  always_comb begin
    drop      = in_valid && full && !rd_en;
    underflow = out_ready && empty;
  end

  // Saturating event counters
  always_ff @(posedge clk_pixel or posedge reset) begin
    if (reset) begin
      overflow_count  <= '0;
      underflow_count <= '0;
    end else begin
      if (drop && overflow_count != '1)       overflow_count  <= overflow_count + 1'b1;
      if (underflow && underflow_count != '1) underflow_count <= underflow_count + 1'b1;
    end
  end
`else
  assign overflow_count  = '0;
  assign underflow_count = '0;
`endif

endmodule

// File: tb/tb_audio_sample_fifo.sv
// Self-checking bench for audio_sample_fifo against a queue-based model.
module tb_audio_sample_fifo;

  localparam int BW    = 16;
  localparam int DEPTH = 8;

  logic                 clk_pixel = 1'b0;
  logic                 reset;
  logic                 in_valid;
  logic signed [BW-1:0] in_left;
  logic signed [BW-1:0] in_right;
  logic                 out_valid;
  logic                 out_ready;
  logic signed [BW-1:0] out_left;
  logic signed [BW-1:0] out_right;
  logic [$clog2(DEPTH):0] fill_level;
  logic [7:0]           overflow_count;
  logic [7:0]           underflow_count;

  audio_sample_fifo #(.BIT_WIDTH(BW), .DEPTH(DEPTH)) dut (
    .clk_pixel      (clk_pixel),
    .reset          (reset),
    .in_valid       (in_valid),
    .in_left        (in_left),
    .in_right       (in_right),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_left       (out_left),
    .out_right      (out_right),
    .fill_level     (fill_level),
    .overflow_count (overflow_count),
    .underflow_count(underflow_count)
  );

  always #5 clk_pixel = ~clk_pixel;

  // Reference model: a queue of {left,right} pairs plus event tallies
  logic [2*BW-1:0] q[$];
  int unsigned     m_ovf;
  int unsigned     m_unf;
  int              errors = 0;
  int              checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [2*BW-1:0] h;
    h = (q.size() > 0) ? q[0] : '0;
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(q.size() > 0));
    chk({tag, ".fill_level"}, 32'(fill_level), 32'(q.size()));
    chk({tag, ".out_left"}, 32'(unsigned'(out_left)), 32'(h[2*BW-1:BW]));
    chk({tag, ".out_right"}, 32'(unsigned'(out_right)), 32'(h[BW-1:0]));
    chk({tag, ".overflow_count"}, 32'(overflow_count), m_ovf);
    chk({tag, ".underflow_count"}, 32'(underflow_count), m_unf);
  endtask

  // One clock: model follows the inputs present at the edge, then check
  task automatic step(input string tag);
    bit rd;
    bit wr;
    @(posedge clk_pixel);
    if (reset) begin
      q.delete();
      m_ovf = 0;
      m_unf = 0;
    end else begin
      rd = (q.size() > 0) && out_ready;
      wr = in_valid && ((q.size() < DEPTH) || rd);
`ifdef AUDIO_FIFO_STATS_EN
      if (in_valid && !wr && m_ovf < 255) m_ovf++;
      if (out_ready && q.size() == 0 && m_unf < 255) m_unf++;
`endif
      if (rd) void'(q.pop_front());
      if (wr) q.push_back({in_left, in_right});
    end
    #1;
    check_all(tag);
  endtask

  task automatic drive(input logic v, input logic [BW-1:0] l, input logic [BW-1:0] r, input logic rdy);
    in_valid  = v;
    in_left   = l;
    in_right  = r;
    out_ready = rdy;
  endtask

  initial begin
    m_ovf = 0;
    m_unf = 0;
    reset = 1'b1;
    drive(1'b1, 16'h5555, 16'hAAAA, 1'b1);

    // Reset state, with inputs active that must be ignored
    step("reset_hold");
    step("reset_hold2");
    reset = 1'b0;
    drive(1'b1, 16'h1234, -16'sd5, 1'b0);

    // First edge after release accepts the sample; fall-through next cycle
    step("first_write");
    chk("first.out_left_const", 32'(unsigned'(out_left)), 32'h1234);
    chk("first.out_right_const", 32'(unsigned'(out_right)), 32'hFFFB);
    chk("first.fill_const", 32'(fill_level), 32'd1);
    drive(1'b0, '0, '0, 1'b1);
    step("first_drain");
    drive(1'b0, '0, '0, 1'b0);
    step("idle");

    // Ten writes into an eight-entry FIFO with no reads: two drops
    for (int i = 1; i <= 10; i++) begin
      drive(1'b1, 16'(i), 16'(-i), 1'b0);
      step("fill10");
    end
    chk("fill10.fill_const", 32'(fill_level), 32'd8);
    chk("fill10.head_const", 32'(unsigned'(out_left)), 32'd1);

    // Simultaneous write and read while full
    drive(1'b1, 16'd11, 16'(-11), 1'b1);
    step("full_rw");
    chk("full_rw.fill_const", 32'(fill_level), 32'd8);
    chk("full_rw.head_const", 32'(unsigned'(out_left)), 32'd2);

    // Drain: 2..8 then 11, in order
    drive(1'b0, '0, '0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      chk("drain.order", 32'(unsigned'(out_left)), (i < 7) ? 32'(i + 2) : 32'd11);
      step("drain");
    end

    // Long underflow burst saturates the counter
    for (int i = 0; i < 300; i++) step("underflow");
`ifdef AUDIO_FIFO_STATS_EN
    chk("underflow.sat_const", 32'(underflow_count), 32'd255);
    chk("overflow.const", 32'(overflow_count), 32'd2);
`else
    chk("underflow.off_const", 32'(underflow_count), 32'd0);
    chk("overflow.off_const", 32'(overflow_count), 32'd0);
`endif

    // Write/read alternation carries the pointers around several times
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 16'(16'h0100 + i), 16'(16'h8000 + i), 1'b0);
      step("wrap_w");
      chk("wrap.fill_le1", 32'(fill_level <= 1), 32'd1);
      chk("wrap.order", 32'(unsigned'(out_left)), 32'(16'h0100 + i));
      drive(1'b0, '0, '0, 1'b1);
      step("wrap_r");
      chk("wrap.fill_le1", 32'(fill_level <= 1), 32'd1);
    end

    // Randomized traffic, biased towards writes in the first half
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(99) < ((i < 200) ? 70 : 35)), 16'($urandom), 16'($urandom),
            ($urandom_range(99) < 45));
      step("random");
    end

    // Bring occupancy to exactly five, then reset between edges
    drive(1'b0, '0, '0, 1'b1);
    for (int i = 0; i < DEPTH + 1; i++) step("pre_drain");
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 16'($urandom), 16'($urandom), 1'b0);
      step("pre_fill5");
    end
    drive(1'b0, '0, '0, 1'b0);
    chk("fill5.const", 32'(fill_level), 32'd5);
    #2 reset = 1'b1;
    drive(1'b1, 16'h7777, 16'h7777, 1'b1);
    #1;
    q.delete();
    m_ovf = 0;
    m_unf = 0;
    check_all("async_reset");
    chk("async_reset.fill_const", 32'(fill_level), 32'd0);
    step("reset_held");
    reset = 1'b0;
    drive(1'b1, 16'h0A0A, 16'hF0F0, 1'b0);
    step("post_reset_write");
    chk("post_reset.fill_const", 32'(fill_level), 32'd1);
    drive(1'b0, '0, '0, 1'b0);
    step("final_idle");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Safety net so the run always ends
  initial begin
    #200000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
